// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, encodings and the decode control bundle of the RV32I core
package riscv_pkg;
   localparam int XLEN        = 32;
   localparam int RESULTSRC_W = 2;
   localparam int ALUCTRL_W   = 3;
   localparam int REGIDX_W    = 5;
   localparam logic [RESULTSRC_W-1:0] RES_ALU = 2'b00;
   localparam logic [RESULTSRC_W-1:0] RES_MEM = 2'b01;
   localparam logic [RESULTSRC_W-1:0] RES_PC4 = 2'b10;
   localparam logic [ALUCTRL_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALUCTRL_W-1:0] ALU_SUB = 3'b001;
   typedef struct packed {
      logic                   reg_write;
      logic                   mem_write;
      logic                   alu_src;
      logic [RESULTSRC_W-1:0] result_src;
      logic [ALUCTRL_W-1:0]   alu_ctrl;
      logic                   branch;
      logic                   jump;
   } ctrl_t;
   // Strobes with architectural side effects are killed for non-instructions;
   // select fields pass through untouched since they are harmless on a dead slot.
   function automatic ctrl_t gate_ctrl(ctrl_t c, logic v);
      ctrl_t g;
      g           = c;
      g.reg_write = c.reg_write & v;
      g.mem_write = c.mem_write & v;
      g.branch    = c.branch & v;
      g.jump      = c.jump & v;
      return g;
   endfunction
endpackage

// File: rtl/pipe_field_reg.sv
// pipe_field_reg: pipeline field-group register with async clear, hold and flush-to-constant
module pipe_field_reg #(
   parameter int             W         = 1,
   parameter logic [W-1:0]   FLUSH_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         flush,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   // flush beats hold beats load; reset is asynchronous and always clears to zero
   always_ff @(posedge clk or posedge rst)
      if (rst)        q <= '0;
      else if (flush) q <= FLUSH_VAL;
      else if (en)    q <= d;
endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with stall, bubble insertion and a saturating bubble counter
module id_ex_pipe_reg #(
   parameter int XLEN  = riscv_pkg::XLEN,
   parameter int CNT_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en_E,
   input  logic            flush_E,
   input  logic            valid_D,
   input  logic            RegWrite_D,
   input  logic            MemWrite_D,
   input  logic            ALUSrc_D,
   input  logic            Branch_D,
   input  logic            Jump_D,
   input  logic [1:0]      ResultSrc_D,
   input  logic [2:0]      ALU_Ctrl_D,
   input  logic [XLEN-1:0] RD1_D,
   input  logic [XLEN-1:0] RD2_D,
   input  logic [XLEN-1:0] ImmExt_D,
   input  logic [XLEN-1:0] PC_D,
   input  logic [XLEN-1:0] PCPlus4_D,
   input  logic [4:0]      Rs1_D,
   input  logic [4:0]      Rs2_D,
   input  logic [4:0]      Rd_D,
   output logic            valid_E,
   output logic            RegWrite_E,
   output logic            MemWrite_E,
   output logic            ALUSrc_E,
   output logic            Branch_E,
   output logic            Jump_E,
   output logic [1:0]      ResultSrc_E,
   output logic [2:0]      ALU_Ctrl_E,
   output logic [XLEN-1:0] RD1_E,
   output logic [XLEN-1:0] RD2_E,
   output logic [XLEN-1:0] ImmExt_E,
   output logic [XLEN-1:0] PC_E,
   output logic [XLEN-1:0] PCPlus4_E,
   output logic [4:0]      Rs1_E,
   output logic [4:0]      Rs2_E,
   output logic [4:0]      Rd_E,
   output logic [CNT_W-1:0] bubble_cnt
);
   import riscv_pkg::*;
   localparam int CW = $bits(ctrl_t) + 1;
   localparam int DW = 5 * XLEN;
   localparam int IW = 3 * REGIDX_W;
   ctrl_t          ctrl_raw;
   ctrl_t          ctrl_d;
   ctrl_t          ctrl_e;
   logic [CW-1:0]  ctrl_q;
   logic [DW-1:0]  data_q;
   logic [IW-1:0]  idx_q;
   assign ctrl_raw = '{reg_write: RegWrite_D, mem_write: MemWrite_D, alu_src: ALUSrc_D,
                       result_src: ResultSrc_D, alu_ctrl: ALU_Ctrl_D,
                       branch: Branch_D, jump: Jump_D};
   assign ctrl_d   = gate_ctrl(ctrl_raw, valid_D);
   pipe_field_reg #(.W(CW)) u_ctrl (
      .clk(clk), .rst(rst), .en(en_E), .flush(flush_E),
      .d({valid_D, ctrl_d}), .q(ctrl_q)
   );
   pipe_field_reg #(.W(DW)) u_data (
      .clk(clk), .rst(rst), .en(en_E), .flush(flush_E),
      .d({RD1_D, RD2_D, ImmExt_D, PC_D, PCPlus4_D}), .q(data_q)
   );
   pipe_field_reg #(.W(IW)) u_idx (
      .clk(clk), .rst(rst), .en(en_E), .flush(flush_E),
      .d({Rs1_D, Rs2_D, Rd_D}), .q(idx_q)
   );
   assign {valid_E, ctrl_e}                          = ctrl_q;
   assign {RD1_E, RD2_E, ImmExt_E, PC_E, PCPlus4_E}  = data_q;
   assign {Rs1_E, Rs2_E, Rd_E}                       = idx_q;
   assign RegWrite_E  = ctrl_e.reg_write;
   assign MemWrite_E  = ctrl_e.mem_write;
   assign ALUSrc_E    = ctrl_e.alu_src;
   assign ResultSrc_E = ctrl_e.result_src;
   assign ALU_Ctrl_E  = ctrl_e.alu_ctrl;
   assign Branch_E    = ctrl_e.branch;
   assign Jump_E      = ctrl_e.jump;
   // count every inserted bubble, sticking at all-ones instead of wrapping
   always_ff @(posedge clk or posedge rst)
      if (rst)                          bubble_cnt <= '0;
      else if (flush_E && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + 1'b1;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: scoreboard bench for the ID/EX register, plus a 2-bit counter instance for saturation
module tb_id_ex_pipe_reg;
   import riscv_pkg::*;
   typedef struct packed {
      logic        valid, rw, mw, as, br, jp;
      logic [1:0]  rs;
      logic [2:0]  ac;
      logic [31:0] rd1, rd2, imm, pc, pc4;
      logic [4:0]  rs1, rs2, rd;
   } flds_t;
   typedef struct packed {
      flds_t       f;
      logic [15:0] cnt;
      logic [1:0]  cnt2;
   } out_t;

   logic clk = 1'b0, rst = 1'b1, en_E = 1'b1, flush_E = 1'b0;
   flds_t din = '1;
   logic        valid_E, RegWrite_E, MemWrite_E, ALUSrc_E, Branch_E, Jump_E;
   logic [1:0]  ResultSrc_E;
   logic [2:0]  ALU_Ctrl_E;
   logic [31:0] RD1_E, RD2_E, ImmExt_E, PC_E, PCPlus4_E;
   logic [4:0]  Rs1_E, Rs2_E, Rd_E;
   logic [15:0] bubble_cnt;
   logic        s_valid, s_rw, s_mw, s_as, s_br, s_jp;
   logic [1:0]  s_rs;
   logic [2:0]  s_ac;
   logic [31:0] s_rd1, s_rd2, s_imm, s_pc, s_pc4;
   logic [4:0]  s_rs1, s_rs2, s_rd;
   logic [1:0]  s_cnt;
   flds_t s_f;
   out_t  obs, model, exp_v;
   out_t  sb[$];
   int cmp = 0, mism = 0;

   always #5 clk = ~clk;

   id_ex_pipe_reg dut (
      .clk(clk), .rst(rst), .en_E(en_E), .flush_E(flush_E), .valid_D(din.valid),
      .RegWrite_D(din.rw), .MemWrite_D(din.mw), .ALUSrc_D(din.as), .Branch_D(din.br),
      .Jump_D(din.jp), .ResultSrc_D(din.rs), .ALU_Ctrl_D(din.ac), .RD1_D(din.rd1),
      .RD2_D(din.rd2), .ImmExt_D(din.imm), .PC_D(din.pc), .PCPlus4_D(din.pc4),
      .Rs1_D(din.rs1), .Rs2_D(din.rs2), .Rd_D(din.rd),
      .valid_E(valid_E), .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E),
      .ALUSrc_E(ALUSrc_E), .Branch_E(Branch_E), .Jump_E(Jump_E),
      .ResultSrc_E(ResultSrc_E), .ALU_Ctrl_E(ALU_Ctrl_E), .RD1_E(RD1_E), .RD2_E(RD2_E),
      .ImmExt_E(ImmExt_E), .PC_E(PC_E), .PCPlus4_E(PCPlus4_E), .Rs1_E(Rs1_E),
      .Rs2_E(Rs2_E), .Rd_E(Rd_E), .bubble_cnt(bubble_cnt)
   );

   id_ex_pipe_reg #(.CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .en_E(en_E), .flush_E(flush_E), .valid_D(din.valid),
      .RegWrite_D(din.rw), .MemWrite_D(din.mw), .ALUSrc_D(din.as), .Branch_D(din.br),
      .Jump_D(din.jp), .ResultSrc_D(din.rs), .ALU_Ctrl_D(din.ac), .RD1_D(din.rd1),
      .RD2_D(din.rd2), .ImmExt_D(din.imm), .PC_D(din.pc), .PCPlus4_D(din.pc4),
      .Rs1_D(din.rs1), .Rs2_D(din.rs2), .Rd_D(din.rd),
      .valid_E(s_valid), .RegWrite_E(s_rw), .MemWrite_E(s_mw), .ALUSrc_E(s_as),
      .Branch_E(s_br), .Jump_E(s_jp), .ResultSrc_E(s_rs), .ALU_Ctrl_E(s_ac),
      .RD1_E(s_rd1), .RD2_E(s_rd2), .ImmExt_E(s_imm), .PC_E(s_pc), .PCPlus4_E(s_pc4),
      .Rs1_E(s_rs1), .Rs2_E(s_rs2), .Rd_E(s_rd), .bubble_cnt(s_cnt)
   );

   assign obs = {valid_E, RegWrite_E, MemWrite_E, ALUSrc_E, Branch_E, Jump_E, ResultSrc_E,
                 ALU_Ctrl_E, RD1_E, RD2_E, ImmExt_E, PC_E, PCPlus4_E, Rs1_E, Rs2_E, Rd_E,
                 bubble_cnt, s_cnt};
   assign s_f = {s_valid, s_rw, s_mw, s_as, s_br, s_jp, s_rs, s_ac, s_rd1, s_rd2, s_imm,
                 s_pc, s_pc4, s_rs1, s_rs2, s_rd};

   function automatic out_t nxt(out_t c, flds_t d, logic f, logic e);
      out_t n;
      n = c;
      if (f) begin
         n.f    = '0;
         n.cnt  = (c.cnt == 16'hFFFF) ? c.cnt : c.cnt + 16'd1;
         n.cnt2 = (c.cnt2 == 2'd3) ? c.cnt2 : c.cnt2 + 2'd1;
      end else if (e) begin
         n.f    = d;
         n.f.rw = d.rw & d.valid;
         n.f.mw = d.mw & d.valid;
         n.f.br = d.br & d.valid;
         n.f.jp = d.jp & d.valid;
      end
      return n;
   endfunction

   function automatic flds_t rnd();
      logic [191:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      return r[185:0];
   endfunction

   task automatic drive_edge(input logic f, input logic e);
      flush_E = f;
      en_E    = e;
      model   = nxt(model, din, f, e);
      sb.push_back(model);
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      #2 rst = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      model = '0;
   endtask

   task automatic test_reset();
      #2;
      cmp++;
      if (obs !== '0) begin mism++; $display("FAIL reset_init: got %h want 0", obs); end
      @(posedge clk);
      #1;
      cmp++;
      if (obs !== '0) begin mism++; $display("FAIL reset_held: got %h want 0", obs); end
      @(negedge clk);
      rst   = 1'b0;
      model = '0;
      din = '0; din.valid = 1; din.rw = 1; din.ac = ALU_ADD; din.rd1 = 32'h5; din.rd2 = 32'h7; din.rd = 5'd3;
      drive_edge(1'b0, 1'b1);
      exp_v = sb.pop_front();
      cmp++;
      if (obs !== exp_v) begin mism++; $display("FAIL add_load: got %h want %h", obs, exp_v); end
      cmp++;
      if ({RegWrite_E, RD1_E, RD2_E, Rd_E} !== {1'b1, 32'h5, 32'h7, 5'd3})
         begin mism++; $display("FAIL add_fields: got %h want %h", {RegWrite_E, RD1_E, RD2_E, Rd_E}, {1'b1, 32'h5, 32'h7, 5'd3}); end
      din = '1;
      drive_edge(1'b0, 1'b1);
      exp_v = sb.pop_front();
      cmp++;
      if (obs !== exp_v) begin mism++; $display("FAIL ones_load: got %h want %h", obs, exp_v); end
      #2 rst = 1'b1;
      #1;
      cmp++;
      if (obs !== '0) begin mism++; $display("FAIL async_reset: got %h want 0", obs); end
      @(negedge clk);
      rst   = 1'b0;
      model = '0;
   endtask

   task automatic test_load();
      din = '0; din.valid = 1; din.rw = 1; din.as = 1; din.rs = RES_MEM; din.imm = 32'h10; din.rs1 = 5'd2; din.rd = 5'd4; din.rd1 = 32'd100;
      drive_edge(1'b0, 1'b1);
      din = '0; din.valid = 1; din.mw = 1; din.as = 1; din.imm = 32'h8; din.rs1 = 5'd2; din.rs2 = 5'd5; din.rd2 = 32'h55;
      exp_v = sb.pop_front();
      cmp++;
      if (obs !== exp_v) begin mism++; $display("FAIL lw_load: got %h want %h", obs, exp_v); end
      cmp++;
      if ({ALUSrc_E, ResultSrc_E, ImmExt_E} !== {1'b1, RES_MEM, 32'h10})
         begin mism++; $display("FAIL lw_fields: got %h want %h", {ALUSrc_E, ResultSrc_E, ImmExt_E}, {1'b1, RES_MEM, 32'h10}); end
      drive_edge(1'b0, 1'b1);
      exp_v = sb.pop_front();
      cmp++;
      if (obs !== exp_v) begin mism++; $display("FAIL sw_load: got %h want %h", obs, exp_v); end
      cmp++;
      if ({RegWrite_E, MemWrite_E} !== 2'b01) begin mism++; $display("FAIL sw_strobes: got %b want 01", {RegWrite_E, MemWrite_E}); end
   endtask

   task automatic test_stall();
      din = '0; din.valid = 1; din.br = 1; din.ac = ALU_SUB; din.pc = 32'h40; din.rs1 = 5'd1; din.rs2 = 5'd2; din.rd1 = 32'd9; din.rd2 = 32'd9;
      drive_edge(1'b0, 1'b1);
      exp_v = sb.pop_front();
      cmp++;
      if (obs !== exp_v) begin mism++; $display("FAIL beq_load: got %h want %h", obs, exp_v); end
      din = '0; din.valid = 1; din.rw = 1; din.jp = 1; din.rs = RES_PC4; din.pc = 32'h44; din.pc4 = 32'h48; din.rd = 5'd1;
      for (int i = 0; i < 3; i++) begin
         drive_edge(1'b0, 1'b0);
         exp_v = sb.pop_front();
         cmp++;
         if (obs !== exp_v) begin mism++; $display("FAIL stall_%0d: got %h want %h", i, obs, exp_v); end
         cmp++;
         if ({Branch_E, Jump_E, PC_E} !== {2'b10, 32'h40})
            begin mism++; $display("FAIL stall_pc_%0d: got %h want %h", i, {Branch_E, Jump_E, PC_E}, {2'b10, 32'h40}); end
      end
      pulse_reset();
      drive_edge(1'b0, 1'b0);
      exp_v = sb.pop_front();
      cmp++;
      if (obs !== '0 || exp_v !== '0) begin mism++; $display("FAIL reset_mid_stall: got %h want 0", obs); end
   endtask

   task automatic test_flush();
      drive_edge(1'b0, 1'b1);
      exp_v = sb.pop_front();
      cmp++;
      if (obs !== exp_v) begin mism++; $display("FAIL jal_load: got %h want %h", obs, exp_v); end
      drive_edge(1'b1, 1'b0);
      exp_v = sb.pop_front();
      cmp++;
      if (obs !== exp_v) begin mism++; $display("FAIL flush_hold: got %h want %h", obs, exp_v); end
      cmp++;
      if ({Jump_E, valid_E, PCPlus4_E, bubble_cnt} !== {2'b00, 32'h0, 16'd1})
         begin mism++; $display("FAIL flush_fields: got %h want %h", {Jump_E, valid_E, PCPlus4_E, bubble_cnt}, {2'b00, 32'h0, 16'd1}); end
      drive_edge(1'b0, 1'b1);
      drive_edge(1'b1, 1'b1);
      for (int i = 0; i < 2; i++) begin
         exp_v = sb.pop_front();
         cmp++;
         if (i == 1 && obs !== exp_v) begin mism++; $display("FAIL flush_load: got %h want %h", obs, exp_v); end
      end
      cmp++;
      if (bubble_cnt !== 16'd2) begin mism++; $display("FAIL flush_cnt2: got %0d want 2", bubble_cnt); end
   endtask

   task automatic test_gating();
      din = '0; din.valid = 0; din.mw = 1; din.rw = 1; din.br = 1; din.jp = 1; din.rd2 = 32'hAB; din.as = 1;
      drive_edge(1'b0, 1'b1);
      exp_v = sb.pop_front();
      cmp++;
      if (obs !== exp_v) begin mism++; $display("FAIL gate_load: got %h want %h", obs, exp_v); end
      cmp++;
      if ({valid_E, RegWrite_E, MemWrite_E, Branch_E, Jump_E, ALUSrc_E, RD2_E} !== {6'b000001, 32'hAB})
         begin mism++; $display("FAIL gate_fields: got %h want %h", {valid_E, RegWrite_E, MemWrite_E, Branch_E, Jump_E, ALUSrc_E, RD2_E}, {6'b000001, 32'hAB}); end
   endtask

   task automatic test_dont_care();
      din = '0; din.valid = 1; din.rw = 1; din.as = 1'bx; din.imm = 'x; din.rs = 'x; din.rd1 = 32'h3; din.rd2 = 32'h4; din.rd = 5'd9;
      drive_edge(1'b0, 1'b1);
      exp_v = sb.pop_front();
      cmp++;
      if (obs !== exp_v) begin mism++; $display("FAIL dont_care: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 40; i++) begin
         din = rnd();
         drive_edge($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
         exp_v = sb.pop_front();
         cmp++;
         if (obs !== exp_v) begin mism++; $display("FAIL b2b_%0d: got %h want %h", i, obs, exp_v); end
      end
   endtask

   task automatic test_saturation();
      logic [1:0] sat_exp [5];
      sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      pulse_reset();
      for (int i = 0; i < 5; i++) begin
         din = rnd();
         drive_edge(1'b1, i[0]);
         exp_v = sb.pop_front();
         cmp++;
         if (obs !== exp_v) begin mism++; $display("FAIL sat_%0d: got %h want %h", i, obs, exp_v); end
         cmp++;
         if (s_cnt !== sat_exp[i] || s_f !== exp_v.f)
            begin mism++; $display("FAIL sat_cnt_%0d: got %0d want %0d", i, s_cnt, sat_exp[i]); end
      end
      cmp++;
      if (bubble_cnt !== 16'd5) begin mism++; $display("FAIL wide_cnt: got %0d want 5", bubble_cnt); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      model = '0;
      test_reset();
      test_load();
      test_stall();
      test_flush();
      test_gating();
      test_dont_care();
      test_back_to_back();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
      $finish;
   end
endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Pipeline register between Decode (ID) and Execute (EX) of the RV32I 5-stage core.
- Captures the decode control bundle (RegWrite, MemWrite, ALUSrc, ResultSrc, ALU_Ctrl, Branch, Jump) together with the register-file operands, immediate, PC values and register indices.
- Supports a stall (hold) input and a flush (bubble insertion) input, driven by the hazard unit.
- Keeps a saturating count of inserted bubbles for debug.

Parameters:
- XLEN, 32, datapath width for operands, immediate and PC fields
- CNT_W, 16, width of the bubble counter

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- en_E  in  1  1 = load new ID values; 0 = hold (stall)
- flush_E  in  1  1 = load a bubble on this edge; overrides en_E
- valid_D  in  1  ID stage holds a real instruction
- RegWrite_D, MemWrite_D, ALUSrc_D, Branch_D, Jump_D  in  1 each  decode control
- ResultSrc_D  in  2  decode result-mux select
- ALU_Ctrl_D  in  3  decode ALU operation
- RD1_D, RD2_D  in  XLEN  register-file read data
- ImmExt_D  in  XLEN  sign-extended immediate
- PC_D, PCPlus4_D  in  XLEN  instruction PC and PC+4
- Rs1_D, Rs2_D, Rd_D  in  5 each  register indices
- valid_E, RegWrite_E, MemWrite_E, ALUSrc_E, Branch_E, Jump_E  out  1 each  registered copies
- ResultSrc_E  out  2  registered copy
- ALU_Ctrl_E  out  3  registered copy
- RD1_E, RD2_E, ImmExt_E, PC_E, PCPlus4_E  out  XLEN  registered copies
- Rs1_E, Rs2_E, Rd_E  out  5  registered copies
- bubble_cnt  out  CNT_W  number of bubbles inserted since reset, saturating

Behaviour:
- Reset (async, rst=1):
  - Every output goes to 0 immediately, independent of clk.
  - The block stays cleared while rst is held.
  - On release, the first rising edge performs a normal update.
- Rising edge, priority flush > hold > load:
  - flush_E=1: load a bubble. valid_E, RegWrite_E, MemWrite_E, Branch_E and Jump_E go to 0. ALUSrc_E, ResultSrc_E and ALU_Ctrl_E go to 0. All data and index fields go to 0. bubble_cnt increments.
  - flush_E=0, en_E=0: every output holds its value. bubble_cnt unchanged.
  - flush_E=0, en_E=1: every *_E output takes its *_D input. valid_E takes valid_D.
- Gating: if valid_D=0 on a load, the control strobes (RegWrite_E, MemWrite_E, Branch_E, Jump_E) are forced to 0. Data fields are still captured.
- Latency: exactly one cycle from a *_D input to the matching *_E output. There is no combinational path from input to output.
- Don't-care inputs: X values on ALUSrc_D, ImmExt_D or ResultSrc_D (for instructions that do not use them) are passed through unchanged on a load. Checkers mask these fields for the matching opcodes.
- Simultaneous flush_E=1 and en_E=0: flush wins and a bubble is inserted.
- bubble_cnt:
  - Increments by 1 on each flush edge.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by rst.
- Reset mid-stall: rst clears the held state. The stall does not re-hold old values after reset.

Decomposition:
- Shared package (riscv_pkg):
  - XLEN
  - Widths RESULTSRC_W=2, ALUCTRL_W=3, REGIDX_W=5
  - Encodings RES_ALU=00, RES_MEM=01, RES_PC4=10
  - ALU codes ALU_ADD=000, ALU_SUB=001
  - The control-bundle struct/typedef, shared by the control unit and this register
- Natural sub-module: pipe_field_reg. It is a parameterised-width register with async reset, enable, flush-to-zero and a configurable flush value. It is instantiated once per field group (control, data, indices), so the EX/MEM and MEM/WB registers can reuse it.

Test Plan:
- Reset: assert rst mid-cycle with all inputs at 1 → all outputs read 0 before the next edge and bubble_cnt=0. Release rst, apply ADD bundle (RegWrite=1, ALU_Ctrl=000, RD1=0x5, RD2=0x7, Rd=3) → next edge gives RegWrite_E=1, RD1_E=0x5, RD2_E=0x7, Rd_E=3.
- Normal load: LW bundle (RegWrite=1, ALUSrc=1, ResultSrc=01, ImmExt=0x10) followed by SW bundle → one-cycle delayed copies appear. SW gives RegWrite_E=0, MemWrite_E=1.
- Stall: load BEQ (Branch=1, ALU_Ctrl=001, PC=0x40), then en_E=0 for 3 edges while inputs change to JAL → outputs stay at BEQ values with PC_E=0x40.
- Flush priority: flush_E=1 and en_E=0 together with a JAL bundle (Jump=1, PCPlus4=0x48) → Jump_E=0, valid_E=0, PCPlus4_E=0, bubble_cnt increments by 1.
- Valid gating: valid_D=0 with MemWrite_D=1, RD2=0xAB → MemWrite_E=0, RD2_E=0xAB.
- Saturation: set CNT_W=2 and apply 5 consecutive flushes → bubble_cnt sequence 1,2,3,3,3.
